// File: rtl/rram_cmd_sequencer_if.sv
// Host request and RRAM controller signals for rram_cmd_sequencer.
// RD_ERR exists only when RRAM_SEQ_SA_TIMEOUT_EN is defined.
interface rram_cmd_sequencer_if #(
  parameter int unsigned B_SIZE = 2,
  parameter int unsigned X_SIZE = 4,
  parameter int unsigned Y_SIZE = 5
);
  logic                     REQ_VALID;
  logic                     REQ_READY;
  logic                     REQ_RW;
  logic [X_SIZE+Y_SIZE-1:0] REQ_ADDR;
  logic [B_SIZE-1:0]        REQ_WDATA;
  logic                     EN;
  logic                     RW;
  logic [X_SIZE-1:0]        X_ADDRESS_OUT;
  logic [Y_SIZE-1:0]        Y_ADDRESS_OUT;
  logic [B_SIZE-1:0]        WDATA_OUT;
  logic                     EN_SA;
  logic [B_SIZE-1:0]        SA_OUT;
  logic [B_SIZE-1:0]        RDATA;
  logic                     RDATA_VALID;
  logic                     BUSY;
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
  logic                     RD_ERR;
`endif

  modport slave (
    input  REQ_VALID, REQ_RW, REQ_ADDR, REQ_WDATA, EN_SA, SA_OUT,
    output REQ_READY, EN, RW, X_ADDRESS_OUT, Y_ADDRESS_OUT, WDATA_OUT,
           RDATA, RDATA_VALID, BUSY
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
    , output RD_ERR
`endif
  );

  modport master (
    output REQ_VALID, REQ_RW, REQ_ADDR, REQ_WDATA, EN_SA, SA_OUT,
    input  REQ_READY, EN, RW, X_ADDRESS_OUT, Y_ADDRESS_OUT, WDATA_OUT,
           RDATA, RDATA_VALID, BUSY
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
    , input RD_ERR
`endif
  );
endinterface

// File: rtl/rram_cmd_sequencer.sv
// Request FIFO plus single-issue command sequencer in front of the RRAM array controller.
// Define RRAM_SEQ_SA_TIMEOUT_EN to flag reads that finish without a sense-amp strobe (RD_ERR).
module rram_cmd_sequencer #(
  parameter int unsigned B_SIZE    = 2,
  parameter int unsigned X_SIZE    = 4,
  parameter int unsigned Y_SIZE    = 5,
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned RD_CYCLES = 4,
  parameter int unsigned WR_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  rram_cmd_sequencer_if.slave bus
);
  localparam int unsigned Depth  = 1 << FIFO_AW;
  localparam int unsigned EW     = 1 + X_SIZE + Y_SIZE + B_SIZE;
  localparam int unsigned MaxCyc = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc);

  localparam logic [FIFO_AW:0] FullCnt = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [CntW-1:0]  RdLoad  = CntW'(RD_CYCLES - 1);
  localparam logic [CntW-1:0]  WrLoad  = CntW'(WR_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [EW-1:0]      mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full, empty, push, pop;
  logic [EW-1:0]      head;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rw_q;
  logic [X_SIZE-1:0] x_q;
  logic [Y_SIZE-1:0] y_q;
  logic [B_SIZE-1:0] wdata_q;
  logic              sa_seen_q, sa_seen_d;
  logic [B_SIZE-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
  logic              rd_err_q, rd_err_d;
`endif

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  assign push  = bus.REQ_VALID && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sa_seen_d = sa_seen_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
    rd_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d     = rw_q ? RdLoad : WrLoad;
        sa_seen_d = 1'b0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Only the first strobe of a read is captured.
        if (rw_q && !sa_seen_q && bus.EN_SA) begin
          sa_seen_d = 1'b1;
          rdata_d   = bus.SA_OUT;
          rvalid_d  = 1'b1;
        end
        if (cnt_q == CntW'(1)) begin
          state_d = S_IDLE;
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
          if (rw_q && !sa_seen_q && !bus.EN_SA) begin
            rvalid_d = 1'b1;
            rd_err_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.REQ_RW, bus.REQ_ADDR, bus.REQ_WDATA};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      wdata_q   <= '0;
      sa_seen_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rw_q     <= head[EW-1];
        y_q      <= head[B_SIZE+X_SIZE +: Y_SIZE];
        x_q      <= head[B_SIZE +: X_SIZE];
        wdata_q  <= head[B_SIZE-1:0];
      end
      count_q   <= count_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sa_seen_q <= sa_seen_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

`ifdef RRAM_SEQ_SA_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_err_q <= 1'b0;
    else        rd_err_q <= rd_err_d;
  end
  assign bus.RD_ERR = rd_err_q;
`endif

  assign bus.REQ_READY     = !full;
  assign bus.EN            = (state_q == S_ISSUE);
  assign bus.RW            = rw_q;
  assign bus.X_ADDRESS_OUT = x_q;
  assign bus.Y_ADDRESS_OUT = y_q;
  assign bus.WDATA_OUT     = wdata_q;
  assign bus.RDATA         = rdata_q;
  assign bus.RDATA_VALID   = rvalid_q;
  assign bus.BUSY          = (state_q != S_IDLE) || !empty;
endmodule

// File: tb/tb_rram_cmd_sequencer.sv
// Bench for rram_cmd_sequencer: directed steps plus random traffic against a cycle-level
// model built from request arrival times, command lengths and sense-amp strobe times.
module tb_rram_cmd_sequencer;
  localparam int unsigned B     = 2;
  localparam int unsigned XS    = 4;
  localparam int unsigned YS    = 5;
  localparam int unsigned FAW   = 2;
  localparam int          RD    = 4;
  localparam int          WR    = 2;
  localparam int          Depth = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rram_cmd_sequencer_if #(.B_SIZE(B), .X_SIZE(XS), .Y_SIZE(YS)) bus ();

  rram_cmd_sequencer #(
    .B_SIZE(B), .X_SIZE(XS), .Y_SIZE(YS), .FIFO_AW(FAW), .RD_CYCLES(RD), .WR_CYCLES(WR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit            rw;
    logic [XS-1:0] x;
    logic [YS-1:0] y;
    logic [B-1:0]  wd;
    int            push_cyc;
  } req_t;

  req_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            ready_cyc, rv_cyc, sa1_cyc, sa2_cyc, wr_noise_cyc;
  bit            rv_err;
  logic [B-1:0]  rv_data, sa1_d, sa2_d, model_rdata, sa_fix;
  bit            h_rw;
  logic [XS-1:0] h_x;
  logic [YS-1:0] h_y;
  logic [B-1:0]  h_wd;
  int            sa_pct = 100;
  int            sa_phase = 0;
  bit            sa_fix_en = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ready_cyc = 0; rv_cyc = -1; sa1_cyc = -1; sa2_cyc = -1; wr_noise_cyc = -1;
    rv_err = 0; rv_data = '0; model_rdata = '0;
    h_rw = 0; h_x = '0; h_y = '0; h_wd = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_en"}, bus.EN, 0);
    check({pfx, "_rw"}, bus.RW, 0);
    check({pfx, "_x"}, bus.X_ADDRESS_OUT, 0);
    check({pfx, "_y"}, bus.Y_ADDRESS_OUT, 0);
    check({pfx, "_wdata"}, bus.WDATA_OUT, 0);
    check({pfx, "_rdata"}, bus.RDATA, 0);
    check({pfx, "_rvalid"}, bus.RDATA_VALID, 0);
    check({pfx, "_busy"}, bus.BUSY, 0);
    check({pfx, "_ready"}, bus.REQ_READY, 1);
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
    check({pfx, "_rd_err"}, bus.RD_ERR, 0);
`endif
  endtask

  // Expected behaviour of the current cycle, sampled at the falling edge.
  task automatic monitor();
    bit   exp_en;
    req_t h;
    int   ph;
    exp_en = reset && q.size() > 0 && q[0].push_cyc <= cyc - 1 && cyc - 1 >= ready_cyc;
    check("en", bus.EN, exp_en);
    if (exp_en) begin
      h = q.pop_front();
      h_rw = h.rw; h_x = h.x; h_y = h.y; h_wd = h.wd;
      ready_cyc = cyc + (h.rw ? RD : WR);
      sa1_cyc = -1; sa2_cyc = -1;
      if (h.rw) begin
        if (int'($urandom_range(0, 99)) < sa_pct) begin
          ph = (sa_phase != 0) ? sa_phase : int'($urandom_range(1, RD - 1));
          sa1_cyc = cyc + ph;
          sa1_d = sa_fix_en ? sa_fix : B'($urandom);
          sa2_d = B'($urandom);
          sa2_cyc = (sa1_cyc < cyc + RD - 1) ? sa1_cyc + 1 : -1;
          rv_cyc = sa1_cyc + 1; rv_data = sa1_d; rv_err = 0;
        end else begin
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
          rv_cyc = cyc + RD; rv_err = 1;
`else
          rv_cyc = -1;
`endif
        end
      end else begin
        wr_noise_cyc = cyc + 1;
      end
    end
    check("rw_out", bus.RW, h_rw);
    check("x_out", bus.X_ADDRESS_OUT, h_x);
    check("y_out", bus.Y_ADDRESS_OUT, h_y);
    check("wdata_out", bus.WDATA_OUT, h_wd);
    check("req_ready", bus.REQ_READY, q.size() < Depth);
    check("busy", bus.BUSY, (q.size() > 0) || (cyc < ready_cyc));
    if (cyc == rv_cyc) begin
      check("rdata_valid", bus.RDATA_VALID, 1);
      if (!rv_err) model_rdata = rv_data;
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
      check("rd_err", bus.RD_ERR, rv_err);
`endif
    end else begin
      check("rdata_valid", bus.RDATA_VALID, 0);
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
      check("rd_err", bus.RD_ERR, 0);
`endif
    end
    check("rdata", bus.RDATA, model_rdata);
  endtask

  // Controller-side inputs for the current cycle; the write strobe is noise to be ignored.
  task automatic drive_sa();
    bus.EN_SA  = reset && ((cyc == sa1_cyc) || (cyc == sa2_cyc) || (cyc == wr_noise_cyc));
    bus.SA_OUT = (cyc == sa2_cyc) ? sa2_d : sa1_d;
  endtask

  task automatic tick();
    bit   acc;
    req_t r;
    acc  = bus.REQ_VALID && bus.REQ_READY;
    r.rw = bus.REQ_RW;
    r.x  = bus.REQ_ADDR[XS-1:0];
    r.y  = bus.REQ_ADDR[XS+YS-1:XS];
    r.wd = bus.REQ_WDATA;
    @(posedge clk);
    cyc++;
    if (acc && reset) begin
      r.push_cyc = cyc;
      q.push_back(r);
    end
    @(negedge clk);
    monitor();
    drive_sa();
  endtask

  task automatic send(input bit rw, input logic [XS-1:0] x, input logic [YS-1:0] y,
                      input logic [B-1:0] wd, input int max_wait);
    bit done;
    done = 0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_RW    = rw;
    bus.REQ_ADDR  = {y, x};
    bus.REQ_WDATA = wd;
    for (int i = 0; i < max_wait && !done; i++) begin
      done = bus.REQ_READY;
      tick();
    end
    bus.REQ_VALID = 1'b0;
    check("accept", done, 1);
  endtask

  task automatic idle(input int n);
    bus.REQ_VALID = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int rvc;
    bus.REQ_VALID = 1'b0; bus.REQ_RW = 1'b0; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
    bus.EN_SA = 1'b0; bus.SA_OUT = '0;
    sa1_d = '0; sa2_d = '0; sa_fix = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    idle(2);

    // Single write: EN one cycle after the accepting edge's successor, fields routed.
    send(1'b0, 4'd2, 5'd4, 2'b10, 4);
    check("wr_en_early", bus.EN, 0);
    tick();
    check("wr_en", bus.EN, 1);
    check("wr_x", bus.X_ADDRESS_OUT, 2);
    check("wr_y", bus.Y_ADDRESS_OUT, 4);
    check("wr_wdata", bus.WDATA_OUT, 2'b10);
    tick();
    check("wr_en_pulse", bus.EN, 0);
    idle(4);

    // Single read with the strobe in RPH2.
    sa_phase = 2; sa_fix_en = 1; sa_fix = 2'b01;
    send(1'b1, 4'd15, 5'd31, 2'b00, 4);
    n = 0; rvc = 0;
    while (bus.BUSY && n < 20) begin
      tick();
      n++;
      rvc += int'(bus.RDATA_VALID);
    end
    check("rd_busy_cycles", n, 5);
    check("rd_valid_pulses", rvc, 1);
    check("rd_data", bus.RDATA, 2'b01);
    check("rd_rw_held", bus.RW, 1);
    sa_phase = 0; sa_fix_en = 0;
    idle(2);

    // Back-to-back burst behind a busy read fills the FIFO.
    send(1'b1, XS'($urandom), YS'($urandom), B'($urandom), 4);
    for (int k = 0; k < 5; k++)
      send(1'($urandom_range(0, 1)), XS'($urandom), YS'($urandom), B'($urandom), 40);
    idle(30);

    // Random traffic: wraps pointers, mixes push/pop in one cycle.
    sa_pct = 75;
    for (int k = 0; k < 30; k++) begin
      send(1'($urandom_range(0, 1)), XS'($urandom), YS'($urandom), B'($urandom), 40);
      idle(int'($urandom_range(0, 2)));
    end
    idle(30);

    // Reset in the middle of a read with two requests queued behind it.
    sa_pct = 100;
    send(1'b1, 4'd5, 5'd9, 2'b11, 4);
    send(1'b0, 4'd1, 5'd1, 2'b01, 4);
    send(1'b0, 4'd3, 5'd3, 2'b10, 4);
    tick();
    reset = 1'b0;
    bus.EN_SA = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    @(negedge clk);
    idle(2);
    reset = 1'b1;
    idle(10);
    send(1'b0, 4'd7, 5'd17, 2'b01, 4);
    idle(6);

    // Read that never sees a sense-amp strobe.
    sa_pct = 0;
    send(1'b1, 4'd8, 5'd12, 2'b00, 4);
    rvc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      rvc += int'(bus.RDATA_VALID);
    end
`ifdef RRAM_SEQ_SA_TIMEOUT_EN
    check("timeout_pulses", rvc, 1);
`else
    check("timeout_pulses", rvc, 0);
`endif
    check("timeout_rdata_hold", bus.RDATA, model_rdata);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
